ram_master: RTL and testbench
=============================

RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 Parameter ADDR_W, default 5: RAM address width; the RAM depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 9: RAM data word width.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port res, input, 1: reset, synchronous and active-high.
REQ-005 Port cmd_valid, input, 1: the requester presents a command.
REQ-006 Port cmd_ready, output, 1: the block accepts a command this cycle.
REQ-007 Port cmd_wr, input, 1: 1 = write, 0 = read; ignored when cmd_clr=1.
REQ-008 Port cmd_clr, input, 1: 1 = clear the whole RAM to zero.
REQ-009 Port cmd_addr, input, ADDR_W: command address.
REQ-010 Port cmd_data, input, DATA_W: write data.
REQ-011 Port rsp_valid, output, 1: one-cycle pulse marking valid read data.
REQ-012 Port rsp_data, output, DATA_W: read data; meaningful only while rsp_valid=1.
REQ-013 Port busy, output, 1: the block is in any state other than IDLE.
REQ-014 Port ram_wr, output, 1: RAM write enable.
REQ-015 Port ram_addr, output, ADDR_W: RAM address.
REQ-016 Port ram_din, output, DATA_W: RAM write data.
REQ-017 Port ram_dout, input, DATA_W: RAM read data; valid on the clock edge after ram_addr is presented with ram_wr=0.

Function
REQ-018 The block SHALL implement FSM states IDLE, WRITE, READ, RWAIT and CLEAR; all outputs are registered.
REQ-019 In IDLE, cmd_ready SHALL be 1; in every other state it SHALL be 0, and cmd_valid SHALL be ignored.
REQ-020 A command SHALL be accepted in cycle N when cmd_valid and cmd_ready are both 1; address and data are latched in that cycle.
REQ-021 A write (cmd_clr=0, cmd_wr=1) SHALL go to WRITE.
- Cycle N+1: ram_wr=1, ram_addr=cmd_addr, ram_din=cmd_data.
- Cycle N+2: back in IDLE with ram_wr=0.
REQ-022 A read (cmd_clr=0, cmd_wr=0) SHALL go READ, then RWAIT, then IDLE.
- Cycle N+1 (READ): ram_addr=cmd_addr, ram_wr=0.
- Cycle N+2 (RWAIT): ram_dout is captured.
- Cycle N+3: rsp_valid=1 and rsp_data=captured word, for exactly one cycle, with cmd_ready=1.
REQ-023 rsp_valid SHALL assert only for reads, with no backpressure; rsp_data SHALL hold its last value while rsp_valid=0.
REQ-024 A clear command (cmd_clr=1) SHALL take priority over cmd_wr and go to CLEAR.
- Cycles N+1 .. N+2**ADDR_W: ram_wr=1, ram_din=0, ram_addr counting 0 upward by 1 per cycle.
- After address 2**ADDR_W-1, return to IDLE with no wrap and no extra write.
REQ-025 The clear address counter SHALL be ADDR_W+1 bits wide so the terminal condition is detected without aliasing at 2**ADDR_W-1.
REQ-026 ram_wr SHALL be 1 only in WRITE and CLEAR.
REQ-027 busy SHALL equal the inverse of cmd_ready.
REQ-028 Back-to-back commands SHALL be supported: a command presented in the cycle cmd_ready returns high is accepted in that cycle.

Reset
REQ-029 When res=1 at a clock edge, the block SHALL enter IDLE with: cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, ram_wr=0, ram_addr=0, ram_din=0, clear counter=0.
REQ-030 Reset asserted mid-operation SHALL abort the operation:
- no further RAM write is issued;
- no rsp_valid pulse is produced;
- a command present with res=1 is not accepted.

Verification
REQ-031 Reset, then write addr=4 data=0x199 -> exactly one ram_wr=1 cycle with ram_addr=4 and ram_din=0x199, one cycle after acceptance.
REQ-032 Read addr=4 after REQ-031 -> rsp_valid pulses once, 3 cycles after acceptance, with rsp_data=0x199.
REQ-033 Write addr=5 data=0x1FF, then immediately read addr=4 -> read accepted in the cycle cmd_ready returns, and rsp_data=0x199 (addr 4 is not disturbed).
REQ-034 Clear command -> 32 consecutive ram_wr cycles covering addresses 0..31 with ram_din=0, busy high throughout; a subsequent read of addr 4 returns 0.
REQ-035 Reset asserted at the 10th clear cycle -> ram_wr=0 on the next cycle, IDLE entered, and addresses 10..31 retain their prior contents.
REQ-036 cmd_valid with cmd_clr=1 and cmd_wr=1 -> the clear sequence runs and no single write occurs.

Source files
------------

// File: rtl/ram_master.sv
// rtl/ram_master.sv - command-driven master for a synchronous single-port RAM
//
// Accepts write, read and clear commands one at a time and drives a RAM
// whose read data appears one clock after the address is presented.
//
// Ports:
//   clk        in   clock, rising edge
//   res        in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted this cycle (high only in IDLE)
//   cmd_wr     in   1 = write, 0 = read (ignored when cmd_clr = 1)
//   cmd_clr    in   1 = zero the whole RAM
//   cmd_addr   in   command address
//   cmd_data   in   write data
//   rsp_valid  out  one-cycle pulse with read data
//   rsp_data   out  read data, held between pulses
//   busy       out  inverse of cmd_ready
//   ram_wr     out  RAM write enable
//   ram_addr   out  RAM address
//   ram_din    out  RAM write data
//   ram_dout   in   RAM read data, valid the cycle after the address
module ram_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              res,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic              cmd_clr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RWAIT,
        S_CLEAR
    } state_t;

    // One past the last RAM address; needs the extra counter bit.
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q;
    logic                cmd_ready_q;
    logic                busy_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                ram_wr_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_din_q;
    // Holds the next clear address; reaching DEPTH ends the sweep.
    logic [ADDR_W:0]     clr_cnt_q;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            clr_cnt_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_clr) begin
                            // Clear wins over cmd_wr; first write goes to address 0.
                            state_q    <= S_CLEAR;
                            ram_wr_q   <= 1'b1;
                            ram_addr_q <= '0;
                            ram_din_q  <= '0;
                            clr_cnt_q  <= (ADDR_W+1)'(1);
                        end else if (cmd_wr) begin
                            state_q    <= S_WRITE;
                            ram_wr_q   <= 1'b1;
                            ram_addr_q <= cmd_addr;
                            ram_din_q  <= cmd_data;
                        end else begin
                            state_q    <= S_READ;
                            ram_addr_q <= cmd_addr;
                        end
                    end
                end
                S_WRITE: begin
                    state_q     <= S_IDLE;
                    ram_wr_q    <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                S_READ: begin
                    // RAM samples the address at this edge; data is valid in RWAIT.
                    state_q <= S_RWAIT;
                end
                S_RWAIT: begin
                    state_q     <= S_IDLE;
                    rsp_data_q  <= ram_dout;
                    rsp_valid_q <= 1'b1;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                S_CLEAR: begin
                    if (clr_cnt_q == DEPTH) begin
                        state_q     <= S_IDLE;
                        ram_wr_q    <= 1'b0;
                        clr_cnt_q   <= '0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        ram_addr_q <= clr_cnt_q[ADDR_W-1:0];
                        clr_cnt_q  <= clr_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    ram_wr_q    <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign ram_wr    = ram_wr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - self-checking bench for ram_master
module tb_ram_master;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 9;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              res;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic              cmd_clr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    always #5 clk = ~clk;

    ram_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .res(res),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_clr(cmd_clr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy),
        .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Synchronous RAM attached to the DUT: read data one clock after address.
    logic [DATA_W-1:0] tb_ram [DEPTH];
    always @(posedge clk) begin
        if (ram_wr) tb_ram[ram_addr] <= ram_din;
        ram_dout <= tb_ram[ram_addr];
    end

    // Reference: expected RAM contents and last response word.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] last_rsp;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic              wr;
        logic              clr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp;
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(n < 200), 1);
    endtask

    // Issue one command at a negedge and follow it until cmd_ready returns.
    task automatic run_cmd(input logic wr, input logic clr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] exp_rd);
        int cyc = 1, ready_cyc = 0, wr_cnt = 0, bus_bad = 0, busy_bad = 0;
        int rsp_cnt = 0, rsp_cyc = 0;
        logic [DATA_W-1:0] rsp_val = '0;
        logic is_rd;
        int exp_len, exp_wr;
        is_rd = !clr && !wr;
        wait_ready();
        cmd_valid = 1'b1; cmd_wr = wr; cmd_clr = clr; cmd_addr = addr; cmd_data = data;
        @(negedge clk);
        // Scramble the now-ignored inputs to prove the command was latched.
        cmd_valid = 1'b0; cmd_wr = 1'($urandom); cmd_clr = 1'($urandom);
        cmd_addr = ADDR_W'($urandom); cmd_data = DATA_W'($urandom);
        check("rsp_hold", rsp_data, last_rsp);
        while (cyc <= DEPTH + 4) begin
            if (busy !== !cmd_ready) busy_bad++;
            if (ram_wr) begin
                wr_cnt++;
                if (clr) begin
                    if (ram_addr != ADDR_W'(cyc - 1) || ram_din != '0) bus_bad++;
                end else if (!wr || cyc != 1 || ram_addr != addr || ram_din != data) begin
                    bus_bad++;
                end
            end
            if (is_rd && cyc == 1 && ram_addr != addr) bus_bad++;
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                rsp_val = rsp_data;
            end
            if (cmd_ready) begin
                ready_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        exp_len = clr ? DEPTH + 1 : (wr ? 2 : 3);
        exp_wr  = clr ? DEPTH : (wr ? 1 : 0);
        check("ready_return_cycle", ready_cyc, exp_len);
        check("ram_wr_count", wr_cnt, exp_wr);
        check("ram_bus_content", bus_bad, 0);
        check("busy_vs_ready", busy_bad, 0);
        check("rsp_count", rsp_cnt, is_rd ? 1 : 0);
        if (is_rd) begin
            check("rsp_cycle", rsp_cyc, 3);
            check("rsp_data", rsp_val, exp_rd);
            last_rsp = exp_rd;
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else if (wr) begin
            ref_mem[addr] = data;
        end
    endtask

    task automatic compare_mem(input string name);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (tb_ram[i] !== ref_mem[i]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        int wcnt;
        int rcnt;
        logic [ADDR_W-1:0] a;
        logic [3:0] r;

        res = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_clr = 1'b0;
        cmd_addr = '0; cmd_data = '0;
        last_rsp = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        vecs[0]  = '{1'b1, 1'b0, 5'd4,  9'h199, 9'h000};
        vecs[1]  = '{1'b0, 1'b0, 5'd4,  9'h000, 9'h199};
        vecs[2]  = '{1'b1, 1'b0, 5'd5,  9'h1FF, 9'h000};
        vecs[3]  = '{1'b0, 1'b0, 5'd4,  9'h000, 9'h199};
        vecs[4]  = '{1'b0, 1'b0, 5'd5,  9'h000, 9'h1FF};
        vecs[5]  = '{1'b1, 1'b1, 5'd5,  9'h1AA, 9'h000};
        vecs[6]  = '{1'b0, 1'b0, 5'd4,  9'h000, 9'h000};
        vecs[7]  = '{1'b1, 1'b0, 5'd31, 9'h0AB, 9'h000};
        vecs[8]  = '{1'b0, 1'b0, 5'd31, 9'h000, 9'h0AB};
        vecs[9]  = '{1'b1, 1'b0, 5'd0,  9'h001, 9'h000};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  9'h000, 9'h001};

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_ram_wr", ram_wr, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        res = 1'b0;

        // Start from a known all-zero RAM.
        run_cmd(1'b0, 1'b1, '0, '0, '0);
        compare_mem("mem_after_first_clear");

        // Directed vectors, issued back-to-back.
        for (int i = 0; i < 11; i++)
            run_cmd(vecs[i].wr, vecs[i].clr, vecs[i].addr, vecs[i].data, vecs[i].exp);
        compare_mem("mem_after_table");

        // Randomized commands against the reference memory.
        for (int i = 0; i < 60; i++) begin
            r = 4'($urandom);
            a = ADDR_W'($urandom);
            if (r == 4'd0)   run_cmd(1'($urandom), 1'b1, a, DATA_W'($urandom), '0);
            else if (r[0])   run_cmd(1'b1, 1'b0, a, DATA_W'($urandom), '0);
            else             run_cmd(1'b0, 1'b0, a, '0, ref_mem[a]);
        end
        compare_mem("mem_after_random");

        // Fill every address with non-zero data before the aborted clear.
        for (int i = 0; i < DEPTH; i++)
            run_cmd(1'b1, 1'b0, ADDR_W'(i), DATA_W'($urandom_range(1, 511)), '0);

        // Reset during the 10th clear cycle; a command offered under reset is dropped.
        wait_ready();
        cmd_valid = 1'b1; cmd_clr = 1'b1; cmd_wr = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_clr = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        check("clr10_ram_wr", ram_wr, 1);
        check("clr10_ram_addr", ram_addr, 9);
        res = 1'b1;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 5'd20; cmd_data = 9'h055;
        @(negedge clk);
        check("abort_ram_wr", ram_wr, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        res = 1'b0;
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) ref_mem[i] = '0;
        wcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ram_wr) wcnt++;
        end
        check("abort_no_writes", wcnt, 0);
        compare_mem("mem_after_clear_abort");

        // Reset during RWAIT suppresses the response.
        run_cmd(1'b0, 1'b0, 5'd3, '0, ref_mem[3]);
        wait_ready();
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_clr = 1'b0; cmd_addr = 5'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        rcnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid) rcnt++;
            @(negedge clk);
        end
        check("read_abort_no_rsp", rcnt, 0);
        check("read_abort_rsp_data", rsp_data, 0);
        last_rsp = '0;

        // Normal operation resumes after the aborts.
        run_cmd(1'b0, 1'b0, 5'd20, '0, ref_mem[20]);
        compare_mem("mem_final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
